// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES joypad reader: FSM states, button bit
// positions and frame length in pad_clk half-periods.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Latch (2 halves) plus 8 bits of low/high pad_clk halves.
  localparam int unsigned FRAME_HALVES = 18;

endpackage

// File: rtl/nes_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module nes_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Serial reader for one NES joypad: drives latch/clock strobes, shifts in
// eight active-high button bits and presents them as a parallel word.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int unsigned HALF_DIV = 6,
  parameter int unsigned POLL_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] btn,
  output logic       btn_vld,
  output logic       busy
);

  localparam int unsigned DIV_W = $clog2(HALF_DIV);
  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic [GAP_W-1:0] gap;
  logic             data_s;
  logic             div_last;
  logic             trigger;

  nes_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_data),
    .q     (data_s)
  );

  assign div_last = (div == DIV_LAST);
  assign trigger  = start || (en && (gap == GAP_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= '0;
      idx       <= '0;
      shift     <= '0;
      gap       <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      btn       <= '0;
      btn_vld   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
            div       <= '0;
            idx       <= '0;
            gap       <= '0;
          end else if (!en) begin
            gap <= '0;
          end else if (gap != GAP_LAST) begin
            gap <= gap + 1'b1;
          end
        end

        // Latch spans two divider periods; idx[0] marks the second one.
        LATCH: begin
          if (div_last) begin
            div <= '0;
            if (idx[0]) begin
              state     <= SHIFT_LO;
              pad_latch <= 1'b0;
              idx       <= '0;
            end else begin
              idx <= 3'd1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        SHIFT_LO: begin
          if (div_last) begin
            shift[idx] <= data_s;
            pad_clk    <= 1'b1;
            state      <= SHIFT_HI;
            div        <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_last) begin
            pad_clk <= 1'b0;
            div     <= '0;
            if (idx == 3'd7) begin
              state   <= DONE;
              btn     <= shift;
              btn_vld <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= SHIFT_LO;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES pad model.
module tb_nes_pad_reader;

  localparam int unsigned HD  = 4;
  localparam int unsigned GAP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] btn;
  logic       btn_vld;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] pattern = 8'h00;
  logic [7:0] btn_model = 8'h00;
  int pos = 0;

  nes_pad_reader #(.HALF_DIV(HD), .POLL_GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .btn       (btn),
    .btn_vld   (btn_vld),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad: latch reloads bit A, each pad_clk rise advances to the next button.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pos <= 0;
    else           pos <= pos + 1;
  end
  assign pad_data = (pos < 8) ? pattern[pos] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp_btn;
    int         restart_at;
    bit         with_en;
  } vec_t;

  vec_t vecs[5];

  // Trigger at edge k; cycle c below is cycle k+c.
  task automatic run_frame(input vec_t v);
    logic exp_latch, exp_clk, exp_busy, exp_vld;
    logic [7:0] exp_b;
    @(negedge clk);
    pattern = v.pat;
    start   = 1'b1;
    en      = v.with_en;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = (c == v.restart_at);
      if (c == 20) en = 1'b0;
      exp_latch = (c >= 1) && (c <= 2 * HD);
      exp_clk   = (c > 2 * HD) && (c <= 18 * HD) && (((c - 2 * HD - 1) % (2 * HD)) >= HD);
      exp_busy  = (c <= 18 * HD + 1);
      exp_vld   = (c == 18 * HD + 1);
      exp_b     = (c >= 18 * HD + 1) ? v.exp_btn : btn_model;
      check($sformatf("latch_%02h_c%0d", v.pat, c), 32'(pad_latch), 32'(exp_latch));
      check($sformatf("pclk_%02h_c%0d", v.pat, c), 32'(pad_clk), 32'(exp_clk));
      check($sformatf("busy_%02h_c%0d", v.pat, c), 32'(busy), 32'(exp_busy));
      check($sformatf("vld_%02h_c%0d", v.pat, c), 32'(btn_vld), 32'(exp_vld));
      check($sformatf("btn_%02h_c%0d", v.pat, c), 32'(btn), 32'(exp_b));
    end
    btn_model = v.exp_btn;
  endtask

  task automatic find_vld(input int bound, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (btn_vld) begin
        t  = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int t0, t1, t2;
    bit ok;

    vecs[0] = '{8'hA5, 8'hA5, 0, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 0, 1'b0};
    vecs[2] = '{8'h3C, 8'h3C, 30, 1'b0};
    vecs[3] = '{8'h5A, 8'h5A, 0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 0, 1'b0};

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", c), {btn, btn_vld, busy, pad_latch, pad_clk}, 32'h0);
    end

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset 40 cycles into a frame while btn holds 8'hFF.
    @(negedge clk);
    pattern = 8'h81;
    start   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_btn", 32'(btn), 32'hFF);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_btn", 32'(btn), 32'h0);
    check("rst_latch_clk", {pad_latch, pad_clk}, 32'h0);
    check("rst_busy_vld", {busy, btn_vld}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    btn_model = 8'h00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_c%0d", c), {btn, btn_vld, busy, pad_latch}, 32'h0);
    end

    // Auto poll.
    pattern = 8'h01;
    en      = 1'b1;
    find_vld(400, t0, ok);
    check("auto_vld0_seen", 32'(ok), 32'h1);
    check("auto_btn0", 32'(btn), 32'h01);
    find_vld(400, t1, ok);
    check("auto_vld1_seen", 32'(ok), 32'h1);
    check("auto_period1", 32'(t1 - t0), 32'(18 * HD + 1 + GAP));
    find_vld(400, t2, ok);
    check("auto_vld2_seen", 32'(ok), 32'h1);
    check("auto_period2", 32'(t2 - t1), 32'(18 * HD + 1 + GAP));
    check("auto_btn2", 32'(btn), 32'h01);
    en = 1'b0;
    repeat (100) @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("auto_off_c%0d", c), {busy, pad_latch, btn_vld}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Serial reader for one NES joypad port.
- Drives the pad latch/clock strobes and shifts in the 8 button bits.
- Presents a parallel, active-high button word to the CPU-side controller register.
- Sits directly downstream of the 3-bit pad-pin inverter stage, which converts active-low pad signals to active-high. pad_data here is already active-high: 1 = pressed.

Parameters:
- HALF_DIV, 6: clk cycles per pad_clk half-period and per latch half-width. Legal range is >= 4.
- POLL_GAP, 1000: idle cycles between automatic frames when en=1. Legal range is >= 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: auto-poll enable (level).
- start, input, 1: single-frame request pulse.
- pad_data, input, 1: serial button bit from the inverter stage, asynchronous to clk.
- pad_latch, output, 1: latch strobe to pad, active-high.
- pad_clk, output, 1: shift clock to pad, idle low.
- btn, output, 8: last completed frame. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- btn_vld, output, 1: one-cycle pulse when btn updates.
- busy, output, 1: frame in progress.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low. All outputs are registered.
- Reset values: pad_latch=0, pad_clk=0, btn=8'h00, btn_vld=0, busy=0. State=IDLE, gap counter=0, bit counter=0, sync flops=0.
- Input sync: pad_data passes through a 2-flop synchronizer. All samples use the synchronized value.
- States are IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE. One divider counter runs 0..HALF_DIV-1, plus a 3-bit bit index.
- IDLE, triggers:
  - Frame trigger = start=1, or (en=1 and gap counter == POLL_GAP-1).
  - Trigger sampled at edge k causes LATCH from cycle k+1.
  - The gap counter increments while en=1 in IDLE and clears on trigger or when en=0.
- LATCH: pad_latch=1 for 2*HALF_DIV cycles, then SHIFT_LO with bit index 0.
- SHIFT_LO: pad_clk=0 for HALF_DIV cycles. On its last cycle, sync'd pad_data is written into shift bit[index]. Then go to SHIFT_HI.
- SHIFT_HI: pad_clk=1 for HALF_DIV cycles.
  - If index==7, go to DONE.
  - Otherwise index+1 and go to SHIFT_LO.
- DONE: one cycle. btn <= shift register, btn_vld=1, then IDLE.
- Frame timing: btn_vld is high in cycle k+1+18*HALF_DIV. busy=1 from cycle k+1 through the DONE cycle inclusive.
- btn holds its value between frames. btn_vld is never high in two consecutive cycles.
- start while busy: ignored, not queued.
- en deasserted mid-frame: the frame completes normally, then stays IDLE.
- en and start both active in IDLE: one frame only.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded and btn is cleared.
- The gap counter saturates; it never wraps while in IDLE.

Decomposition:
- Package nes_pad_pkg holds:
  - the state enum (IDLE/LATCH/SHIFT_LO/SHIFT_HI/DONE)
  - button index constants BTN_A..BTN_RIGHT (0..7)
  - the frame-length constant FRAME_HALVES=18
- One sub-module is natural: nes_sync2, a generic 2-flop synchronizer with asynchronous active-low reset, used for pad_data.

Test Plan:
- Reset and idle: HALF_DIV=4, rst_n low then high, en=0, start=0 -> all outputs 0 for 200 cycles, no pad_latch activity.
- Single frame: pulse start at edge k, pad model drives pattern 8'b1010_0101 (A first) -> pad_latch high for cycles k+1..k+8, then 8 pad_clk pulses of 4 low/4 high. btn=8'hA5 with btn_vld pulsing in cycle k+73 only.
- Auto poll: HALF_DIV=4, POLL_GAP=10, en=1, constant pad pattern 8'h01 -> btn_vld every 73+10 cycles, btn=8'h01 each time.
- start while busy: pulse start again mid-frame at cycle k+30 -> exactly one btn_vld, at k+73, and no second frame.
- Reset mid-frame: assert rst_n low at cycle k+40 after a prior btn=8'hFF -> btn=0 and pad_latch/pad_clk=0 immediately. After release, IDLE with no btn_vld.
- en drop mid-frame: en=1 frame running, en=0 at k+20 -> frame completes with btn_vld at k+73, then no further pad_latch.
